// File: rtl/traj_logger.sv
// ============================================================================
// Module   : traj_logger
// Records simulated steps into a drainable FIFO and accumulates episode stats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module traj_logger #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [15:0] step_len_i,
    input  logic [15:0] discount_i,
    input  logic        step_valid_i,
    input  logic [1:0]  action_i,
    input  logic        observation_i,
    input  logic        cur_state_i,
    input  logic [31:0] reward_i,
    input  logic        rd_ready_i,
    output logic        rd_valid_o,
    output logic [35:0] rd_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] step_cnt_o,
    output logic [31:0] total_reward_o,
    output logic [31:0] disc_return_o,
    output logic [15:0] action_cnt_o [0:3],
    output logic        overflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic [15:0] disc_q;
    logic [16:0] gamma_q;
    logic [15:0] step_cnt_q;
    logic [31:0] total_q;
    logic [31:0] ret_q;
    logic [15:0] action_cnt_q [0:3];
    logic        ovf_q;

    logic [35:0] mem_q [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic               accept_w, rd_hs_w, full_w, wr_en_w;
    logic [15:0]        step_cnt_inc_w;
    logic signed [49:0] prod_w;
    logic [32:0]        gprod_w;

    assign accept_w       = (state_q == RUN) && step_valid_i && !start_i;
    assign rd_valid_o     = (count_q != '0);
    assign rd_hs_w        = rd_valid_o && rd_ready_i;
    assign full_w         = (count_q == (AW+1)'(DEPTH));
    // A full FIFO still takes the write when the head leaves in the same cycle.
    assign wr_en_w        = accept_w && (!full_w || rd_hs_w);
    assign step_cnt_inc_w = step_cnt_q + 16'd1;
    assign prod_w         = $signed(reward_i) * $signed({1'b0, gamma_q});
    assign gprod_w        = gamma_q * discount_latched_ext(disc_q);

    function automatic logic [32:0] discount_latched_ext(input logic [15:0] d);
        return {17'd0, d};
    endfunction

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = (step_len_i == 16'd0) ? DONE : RUN;
        end else if (accept_w && (step_cnt_inc_w == len_q)) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            disc_q     <= '0;
            gamma_q    <= 17'h10000;
            step_cnt_q <= '0;
            total_q    <= '0;
            ret_q      <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < 4; i++) action_cnt_q[i] <= '0;
        end else if (start_i) begin
            len_q      <= step_len_i;
            disc_q     <= discount_i;
            gamma_q    <= 17'h10000;
            step_cnt_q <= '0;
            total_q    <= '0;
            ret_q      <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < 4; i++) action_cnt_q[i] <= '0;
        end else if (accept_w) begin
            step_cnt_q <= step_cnt_inc_w;
            total_q    <= total_q + reward_i;
            ret_q      <= ret_q + 32'(prod_w >>> 16);
            gamma_q    <= 17'(gprod_w >> 16);
            if (action_cnt_q[action_i] != 16'hFFFF) begin
                action_cnt_q[action_i] <= action_cnt_q[action_i] + 16'd1;
            end
            if (!wr_en_w) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (start_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_w) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_hs_w) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en_w, rd_hs_w})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_w) begin
            mem_q[wr_ptr_q] <= {action_i, observation_i, cur_state_i, reward_i};
        end
    end

    // Gated so an empty FIFO presents zeros rather than stale storage.
    assign rd_data_o      = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign busy_o         = (state_q == RUN);
    assign done_o         = (state_q == DONE);
    assign step_cnt_o     = step_cnt_q;
    assign total_reward_o = total_q;
    assign disc_return_o  = ret_q;
    assign action_cnt_o   = action_cnt_q;
    assign overflow_o     = ovf_q;

endmodule

`default_nettype wire
